// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial frame transmitter.
//   tx_state_t : frame FSM states (IDLE, START, DATA, STOP)
//   LINE_IDLE / START_BIT / STOP_BIT : serial line levels
package serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_tx_baud_cnt.sv
// Bit-period timer for the serial transmitter.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : force the timer back to 0
//   enable     : advance the timer this cycle
//   tick       : high on the last cycle of each CLKS_PER_BIT-cycle bit period
module baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  generate
    if (CLKS_PER_BIT == 1) begin : g_single
      // Every enabled cycle is a terminal cycle; no counter state exists.
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, reset, clear};
      assign tick      = enable;
    end else begin : g_cnt
      localparam int unsigned   TW   = $clog2(CLKS_PER_BIT);
      localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

      logic [TW-1:0] cnt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt <= '0;
        end else if (clear) begin
          cnt <= '0;
        end else if (enable) begin
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
      end

      assign tick = enable && (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter.
// Accepts a WIDTH-bit word on valid && ready, then sends start bit (0),
// WIDTH data bits (LSB or MSB first), stop bit (1); each bit lasts
// CLKS_PER_BIT cycles. done pulses for one cycle after the stop bit.
//   clk, reset : clock, asynchronous active-high reset
//   p_in, valid: parallel word and its valid strobe
//   ready, busy: idle / frame in progress (decoded from state)
//   s_out      : registered serial line, idle high
//   done       : registered end-of-frame pulse
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          LSB_FIRST    = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] p_in,
  input  logic             valid,
  output logic             ready,
  output logic             s_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned   BW       = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  tx_state_t        state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n, shifted;
  logic [BW-1:0]    bcnt, bcnt_n;
  logic             s_out_n, done_n;
  logic             baud_clear, baud_en, tick;

  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return LSB_FIRST ? v[0] : v[WIDTH-1];
  endfunction

  assign baud_clear = (state == IDLE);
  assign baud_en    = (state != IDLE);

  baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (baud_clear),
    .enable (baud_en),
    .tick   (tick)
  );

  assign ready   = (state == IDLE);
  assign busy    = ~ready;
  assign shifted = LSB_FIRST ? (shreg >> 1) : (shreg << 1);

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    bcnt_n  = bcnt;
    s_out_n = s_out;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        s_out_n = LINE_IDLE;
        if (valid) begin
          shreg_n = p_in;
          state_n = START;
          s_out_n = START_BIT;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          s_out_n = first_bit(shreg);
          bcnt_n  = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_n = shifted;
          if (bcnt == LAST_BIT) begin
            state_n = STOP;
            s_out_n = STOP_BIT;
          end else begin
            bcnt_n  = bcnt + 1'b1;
            s_out_n = first_bit(shifted);
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      bcnt  <= '0;
      s_out <= LINE_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      bcnt  <= bcnt_n;
      s_out <= s_out_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pa, pb;
  logic       va, vb;
  logic       a_ready, a_s, a_busy, a_done;
  logic       b_ready, b_s, b_busy, b_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t1, t2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .p_in(pa), .valid(va),
    .ready(a_ready), .s_out(a_s), .busy(a_busy), .done(a_done)
  );

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .p_in(pb), .valid(vb),
    .ready(b_ready), .s_out(b_s), .busy(b_busy), .done(b_done)
  );

  // Observed vectors are {s_out, busy, done, ready}.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called one step after the accepting edge; returns at the done sample.
  task automatic frame_a(input logic [7:0] d, input int glitch);
    logic exp_s;
    for (int j = 0; j < 40; j++) begin
      if (j < 4)       exp_s = 1'b0;
      else if (j < 36) exp_s = d[(j-4)/4];
      else             exp_s = 1'b1;
      chk("a_frame", {a_s, a_busy, a_done, a_ready}, {exp_s, 1'b1, 1'b0, 1'b0});
      if (j == glitch) begin
        va = 1'b1;
        pa = 8'hFF;
      end else if (j == glitch + 1) begin
        va = 1'b0;
      end
      step();
    end
    chk("a_done", {a_s, a_busy, a_done, a_ready}, 4'b1011);
  endtask

  initial begin
    reset = 1'b1;
    va = 1'b0; pa = 8'h00;
    vb = 1'b0; pb = 8'h00;

    #12;
    chk("rst_a", {a_s, a_busy, a_done, a_ready}, 4'b1001);
    chk("rst_b", {b_s, b_busy, b_done, b_ready}, 4'b1001);
    #18;
    reset = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      chk("idle_a", {a_s, a_busy, a_done, a_ready}, 4'b1001);
      chk("idle_b", {b_s, b_busy, b_done, b_ready}, 4'b1001);
      step();
    end

    // Plain 8'hA5 frame; p_in changed right after capture.
    va = 1'b1; pa = 8'hA5;
    step();
    va = 1'b0; pa = 8'h5A;
    frame_a(8'hA5, 1000);
    step();
    chk("a5_after", {a_s, a_busy, a_done, a_ready}, 4'b1001);

    // Same frame with a valid pulse of 8'hFF while busy.
    va = 1'b1; pa = 8'hA5;
    step();
    va = 1'b0;
    frame_a(8'hA5, 10);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("glitch_idle", {a_s, a_busy, a_done, a_ready}, 4'b1001);
    end

    // Back-to-back with valid held high.
    va = 1'b1; pa = 8'h00;
    step();
    frame_a(8'h00, 1000);
    t1 = cyc;
    pa = 8'hFF;
    step();
    va = 1'b0;
    frame_a(8'hFF, 1000);
    t2 = cyc;
    chk("b2b_gap", t2 - t1, 41);
    step();
    chk("b2b_after", {a_s, a_busy, a_done, a_ready}, 4'b1001);

    // Reset during the 3rd data bit of 8'h3C.
    va = 1'b1; pa = 8'h3C;
    step();
    va = 1'b0;
    for (int i = 0; i < 13; i++) step();
    chk("mid_bit3", {a_s, a_busy, a_done, a_ready}, 4'b1100);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_async", {a_s, a_busy, a_done, a_ready}, 4'b1001);
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 45; i++) begin
      chk("mid_no_done", {a_s, a_busy, a_done, a_ready}, 4'b1001);
      step();
    end
    va = 1'b1; pa = 8'h01;
    step();
    va = 1'b0;
    frame_a(8'h01, 1000);
    step();
    chk("x01_after", {a_s, a_busy, a_done, a_ready}, 4'b1001);

    // One cycle per bit, MSB first, 8'h81.
    begin
      logic [7:0] db;
      logic       exp_b;
      db = 8'h81;
      vb = 1'b1; pb = db;
      step();
      vb = 1'b0;
      for (int j = 0; j < 10; j++) begin
        if (j == 0)      exp_b = 1'b0;
        else if (j < 9)  exp_b = db[8-j];
        else             exp_b = 1'b1;
        chk("b_frame", {b_s, b_busy, b_done, b_ready}, {exp_b, 1'b1, 1'b0, 1'b0});
        step();
      end
      chk("b_done", {b_s, b_busy, b_done, b_ready}, 4'b1011);
      step();
      chk("b_after", {b_s, b_busy, b_done, b_ready}, 4'b1001);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
